// File: rtl/row_accumulator.sv
// Row dot-product accumulator: per lane, pops a row length, sums that many signed
// products from the lane mult FIFO, and offers the sum on a valid/ready result port.
module row_accumulator #(
  parameter int unsigned channel_num  = 4,
  parameter int unsigned val_bits     = 16,
  parameter int unsigned row_len_size = 8,
  parameter int unsigned acc_bits     = 40,
  parameter int unsigned cnt_bits     = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [2*val_bits*channel_num-1:0]     mult,
  input  logic [channel_num-1:0]                mult_fifo_empty,
  output logic [channel_num-1:0]                mult_fifo_read,
  input  logic [row_len_size*channel_num-1:0]   len,
  input  logic [channel_num-1:0]                len_fifo_empty,
  output logic [channel_num-1:0]                len_fifo_read,
  output logic [acc_bits*channel_num-1:0]       res,
  output logic [channel_num-1:0]                res_valid,
  input  logic [channel_num-1:0]                res_ready,
  output logic [cnt_bits*channel_num-1:0]       rows_done
);

  localparam int unsigned prod_bits = 2 * val_bits;

  typedef enum logic [1:0] {
    S_LEN = 2'd0,
    S_ACC = 2'd1,
    S_OUT = 2'd2
  } state_t;

  for (genvar i = 0; i < channel_num; i++) begin : g_lane
    state_t                  state_q, state_d;
    logic [acc_bits-1:0]     acc_q, acc_d;
    logic [row_len_size-1:0] rem_q, rem_d;
    logic                    valid_q, valid_d;
    logic [cnt_bits-1:0]     cnt_q, cnt_d;
    logic                    len_rd, mult_rd;
    logic [prod_bits-1:0]    prod;
    logic [row_len_size-1:0] row_len;
    logic [acc_bits-1:0]     prod_ext;

    assign prod     = mult[i*prod_bits +: prod_bits];
    assign row_len  = len[i*row_len_size +: row_len_size];
    assign prod_ext = acc_bits'($signed(prod));

    // Lane state register; reset discards any partial row.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= S_LEN;
        acc_q   <= '0;
        rem_q   <= '0;
        valid_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        acc_q   <= acc_d;
        rem_q   <= rem_d;
        valid_q <= valid_d;
        cnt_q   <= cnt_d;
      end
    end

    // Next-state and pop strobes; strobes are held low during reset.
    always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      len_rd  = 1'b0;
      mult_rd = 1'b0;
      case (state_q)
        S_LEN: begin
          if (!rst && !len_fifo_empty[i]) begin
            len_rd = 1'b1;
            acc_d  = '0;
            rem_d  = row_len;
            if (row_len == '0) begin
              state_d = S_OUT;
              valid_d = 1'b1;
            end else begin
              state_d = S_ACC;
            end
          end
        end
        S_ACC: begin
          if (!rst && !mult_fifo_empty[i]) begin
            mult_rd = 1'b1;
            acc_d   = acc_q + prod_ext;
            rem_d   = rem_q - row_len_size'(1);
            if (rem_q == row_len_size'(1)) begin
              state_d = S_OUT;
              valid_d = 1'b1;
            end
          end
        end
        S_OUT: begin
          if (res_ready[i]) begin
            cnt_d   = cnt_q + cnt_bits'(1);
            valid_d = 1'b0;
            state_d = S_LEN;
          end
        end
        default: begin
          state_d = S_LEN;
          valid_d = 1'b0;
        end
      endcase
    end

    assign len_fifo_read[i]                  = len_rd;
    assign mult_fifo_read[i]                 = mult_rd;
    assign res[i*acc_bits +: acc_bits]       = acc_q;
    assign res_valid[i]                      = valid_q;
    assign rows_done[i*cnt_bits +: cnt_bits] = cnt_q;
  end

endmodule

// File: tb/tb_row_accumulator.sv
// Directed bench for row_accumulator: FWFT FIFO models per lane, a vector table of
// rows with hand-computed sums, and timed sequences for stalls, backpressure and reset.
module tb_row_accumulator;
  localparam int unsigned CH = 4;
  localparam int unsigned VB = 16;
  localparam int unsigned LB = 8;
  localparam int unsigned AB = 40;
  localparam int unsigned CB = 16;
  localparam int unsigned PB = 2 * VB;

  logic              clk = 1'b0;
  logic              rst;
  logic [PB*CH-1:0]  mult;
  logic [CH-1:0]     mult_fifo_empty;
  logic [CH-1:0]     mult_fifo_read;
  logic [LB*CH-1:0]  len;
  logic [CH-1:0]     len_fifo_empty;
  logic [CH-1:0]     len_fifo_read;
  logic [AB*CH-1:0]  res;
  logic [CH-1:0]     res_valid;
  logic [CH-1:0]     res_ready;
  logic [CB*CH-1:0]  rows_done;

  row_accumulator #(
    .channel_num(CH), .val_bits(VB), .row_len_size(LB), .acc_bits(AB), .cnt_bits(CB)
  ) dut (
    .clk(clk), .rst(rst),
    .mult(mult), .mult_fifo_empty(mult_fifo_empty), .mult_fifo_read(mult_fifo_read),
    .len(len), .len_fifo_empty(len_fifo_empty), .len_fifo_read(len_fifo_read),
    .res(res), .res_valid(res_valid), .res_ready(res_ready), .rows_done(rows_done)
  );

  always #5 clk = ~clk;

  logic [PB-1:0] mmem [CH][64];
  logic [LB-1:0] lmem [CH][64];
  logic [5:0]    mrp [CH] = '{default: 6'd0};
  logic [5:0]    mwp [CH] = '{default: 6'd0};
  logic [5:0]    lrp [CH] = '{default: 6'd0};
  logic [5:0]    lwp [CH] = '{default: 6'd0};
  logic [CH-1:0] stall = '0;
  logic [CH-1:0] flush = '0;
  int            checks = 0;
  int            errors = 0;
  int            exp_rows [CH];

  typedef struct {
    int          lane;
    int          n;
    logic [31:0] p [4];
    logic [39:0] exp;
  } vec_t;
  vec_t tbl [8];
  int   nvec = 0;

  // FWFT heads; stall forces a lane mult FIFO to look empty.
  always_comb begin
    mult = '0;
    len  = '0;
    mult_fifo_empty = '0;
    len_fifo_empty  = '0;
    for (int i = 0; i < CH; i++) begin
      mult[i*PB +: PB]   = mmem[i][mrp[i]];
      len[i*LB +: LB]    = lmem[i][lrp[i]];
      mult_fifo_empty[i] = (mrp[i] == mwp[i]) || stall[i];
      len_fifo_empty[i]  = (lrp[i] == lwp[i]);
    end
  end

  // Pop on strobe; flag any strobe raised against an empty FIFO.
  always @(posedge clk) begin
    for (int i = 0; i < CH; i++) begin
      checks++;
      if ((mult_fifo_read[i] && mult_fifo_empty[i]) || (len_fifo_read[i] && len_fifo_empty[i])) begin
        errors++;
        $display("FAIL pop_while_empty lane%0d mrd=%b mempty=%b lrd=%b lempty=%b",
                 i, mult_fifo_read[i], mult_fifo_empty[i], len_fifo_read[i], len_fifo_empty[i]);
      end
      if (flush[i]) begin
        mrp[i] <= mwp[i];
        lrp[i] <= lwp[i];
      end else begin
        if (mult_fifo_read[i]) mrp[i] <= mrp[i] + 6'd1;
        if (len_fifo_read[i])  lrp[i] <= lrp[i] + 6'd1;
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push_m(input int l, input logic [31:0] v);
    mmem[l][mwp[l]] = v;
    mwp[l] = mwp[l] + 6'd1;
  endtask

  task automatic push_l(input int l, input logic [7:0] v);
    lmem[l][lwp[l]] = v;
    lwp[l] = lwp[l] + 6'd1;
  endtask

  function automatic logic [39:0] res_of(input int l);
    return res[l*AB +: AB];
  endfunction

  function automatic logic [15:0] rows_of(input int l);
    return rows_done[l*CB +: CB];
  endfunction

  task automatic wait_valid(input int l, output int k);
    k = 0;
    while (!res_valid[l] && k < 40) begin
      step();
      k++;
    end
  endtask

  task automatic handshake(input int l);
    res_ready[l] = 1'b1;
    #1;
    chk($sformatf("hs_no_len_pop_l%0d", l), 64'(len_fifo_read[l]), 64'd0);
    step();
    res_ready[l] = 1'b0;
    #1;
    exp_rows[l]++;
    chk($sformatf("rows_done_l%0d", l), 64'(rows_of(l)), 64'(exp_rows[l]));
    chk($sformatf("valid_drop_l%0d", l), 64'(res_valid[l]), 64'd0);
  endtask

  task automatic add_vec(input int l, input int n, input logic [31:0] p0, input logic [31:0] p1,
                         input logic [31:0] p2, input logic [31:0] p3, input logic [39:0] e);
    tbl[nvec].lane = l;
    tbl[nvec].n    = n;
    tbl[nvec].p[0] = p0;
    tbl[nvec].p[1] = p1;
    tbl[nvec].p[2] = p2;
    tbl[nvec].p[3] = p3;
    tbl[nvec].exp  = e;
    nvec++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    add_vec(0, 1, 32'hFFFFFFFF, 0, 0, 0, 40'hFF_FFFF_FFFF);
    add_vec(0, 2, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0, 40'h00_FFFF_FFFE);
    add_vec(1, 3, 32'd16, 32'hFFFFFFF0, 32'd5, 0, 40'd5);
    add_vec(2, 4, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 40'hFF_FFFF_FFF8);
    add_vec(3, 0, 0, 0, 0, 0, 40'd0);
    add_vec(3, 2, 32'h80000000, 32'h80000000, 0, 0, 40'hFF_0000_0000);
    add_vec(1, 4, 32'd3, 32'd4, 32'd5, 32'd6, 40'd18);
    for (int i = 0; i < CH; i++) exp_rows[i] = 0;

    // Reset with data waiting: no strobes, cleared outputs.
    rst = 1'b1;
    res_ready = '0;
    push_l(0, 8'd3);
    push_m(0, 32'd2);
    push_m(0, 32'd3);
    push_m(0, 32'hFFFFFFFF);
    step();
    step();
    chk("rst_len_rd", 64'(len_fifo_read), 64'd0);
    chk("rst_mult_rd", 64'(mult_fifo_read), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_rows", 64'(rows_done), 64'd0);
    chk("rst_res0", 64'(res_of(0)), 64'd0);

    // Basic row: len 3 popped in cycle 0, products in 1..3, valid in 4.
    rst = 1'b0;
    #1;
    chk("t1_c0_len_rd", 64'(len_fifo_read), 64'h1);
    chk("t1_c0_mult_rd", 64'(mult_fifo_read), 64'h0);
    for (int c = 1; c <= 3; c++) begin
      step();
      chk($sformatf("t1_c%0d_mult_rd", c), 64'(mult_fifo_read), 64'h1);
      chk($sformatf("t1_c%0d_len_rd", c), 64'(len_fifo_read), 64'h0);
      chk($sformatf("t1_c%0d_valid", c), 64'(res_valid), 64'h0);
    end
    step();
    chk("t1_c4_valid", 64'(res_valid), 64'h1);
    chk("t1_c4_res", 64'(res_of(0)), 64'd4);
    chk("t1_c4_mult_rd", 64'(mult_fifo_read), 64'h0);
    handshake(0);

    // Zero-length row, and no length pop until the handshake completes.
    push_l(0, 8'd0);
    push_l(0, 8'd1);
    push_m(0, 32'd7);
    #1;
    chk("t2_c0_len_rd", 64'(len_fifo_read[0]), 64'd1);
    step();
    chk("t2_c1_valid", 64'(res_valid[0]), 64'd1);
    chk("t2_c1_res", 64'(res_of(0)), 64'd0);
    chk("t2_c1_mult_rd", 64'(mult_fifo_read[0]), 64'd0);
    chk("t2_c1_len_rd", 64'(len_fifo_read[0]), 64'd0);
    step();
    chk("t2_c2_len_rd", 64'(len_fifo_read[0]), 64'd0);
    handshake(0);
    chk("t2_next_len_rd", 64'(len_fifo_read[0]), 64'd1);
    step();
    chk("t2_next_mult_rd", 64'(mult_fifo_read[0]), 64'd1);
    step();
    chk("t2_next_valid", 64'(res_valid[0]), 64'd1);
    chk("t2_next_res", 64'(res_of(0)), 64'd7);
    handshake(0);

    // Vector table: sums, sign extension, wrap-free boundaries, latency n+1.
    for (int v = 0; v < nvec; v++) begin
      push_l(tbl[v].lane, 8'(tbl[v].n));
      for (int j = 0; j < tbl[v].n; j++) push_m(tbl[v].lane, tbl[v].p[j]);
      #1;
      wait_valid(tbl[v].lane, k);
      chk($sformatf("vec%0d_latency", v), 64'(k), 64'(tbl[v].n + 1));
      chk($sformatf("vec%0d_res", v), 64'(res_of(tbl[v].lane)), 64'(tbl[v].exp));
      handshake(tbl[v].lane);
    end

    // Lane1 stall after the 2nd product for 3 cycles.
    push_l(1, 8'd4);
    for (int j = 0; j < 4; j++) push_m(1, 32'd1);
    #1;
    chk("t3_c0_len_rd", 64'(len_fifo_read[1]), 64'd1);
    step();
    chk("t3_c1_mult_rd", 64'(mult_fifo_read[1]), 64'd1);
    step();
    chk("t3_c2_mult_rd", 64'(mult_fifo_read[1]), 64'd1);
    step();
    stall[1] = 1'b1;
    #1;
    for (int c = 3; c <= 5; c++) begin
      if (c > 3) step();
      chk($sformatf("t3_c%0d_stall_rd", c), 64'(mult_fifo_read[1]), 64'd0);
      chk($sformatf("t3_c%0d_valid", c), 64'(res_valid[1]), 64'd0);
    end
    step();
    stall[1] = 1'b0;
    #1;
    chk("t3_c6_mult_rd", 64'(mult_fifo_read[1]), 64'd1);
    step();
    chk("t3_c7_mult_rd", 64'(mult_fifo_read[1]), 64'd1);
    chk("t3_c7_valid", 64'(res_valid[1]), 64'd0);
    step();
    chk("t3_c8_valid", 64'(res_valid[1]), 64'd1);
    chk("t3_c8_res", 64'(res_of(1)), 64'd4);
    handshake(1);

    // Lane2 backpressured for 10 cycles while lane3 finishes two rows.
    push_l(2, 8'd1);
    push_m(2, 32'd9);
    push_l(2, 8'd1);
    push_m(2, 32'd1);
    res_ready[3] = 1'b1;
    push_l(3, 8'd2);
    push_m(3, 32'd1);
    push_m(3, 32'd2);
    push_l(3, 8'd1);
    push_m(3, 32'd4);
    step();
    step();
    chk("t4_l2_valid", 64'(res_valid[2]), 64'd1);
    chk("t4_l2_res", 64'(res_of(2)), 64'd9);
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("t4_hold%0d", c),
          {22'd0, res_valid[2], len_fifo_read[2], mult_fifo_read[2], res_of(2)},
          {22'd0, 1'b1, 1'b0, 1'b0, 40'd9});
    end
    exp_rows[3] += 2;
    chk("t4_l3_rows", 64'(rows_of(3)), 64'(exp_rows[3]));
    res_ready[3] = 1'b0;
    handshake(2);
    wait_valid(2, k);
    chk("t4_l2_row2_latency", 64'(k), 64'd2);
    chk("t4_l2_row2_res", 64'(res_of(2)), 64'd1);
    handshake(2);

    // Reset mid-row on lane0 with lane1 holding a valid result.
    push_l(0, 8'd4);
    for (int j = 0; j < 4; j++) push_m(0, 32'd5);
    push_l(1, 8'd0);
    step();
    step();
    step();
    chk("t6_pre_valid1", 64'(res_valid[1]), 64'd1);
    chk("t6_pre_mult_left", 64'(mwp[0] - mrp[0]), 64'd2);
    rst = 1'b1;
    flush = '1;
    #1;
    chk("t6_rst_len_rd", 64'(len_fifo_read), 64'd0);
    chk("t6_rst_mult_rd", 64'(mult_fifo_read), 64'd0);
    chk("t6_rst_valid", 64'(res_valid), 64'd0);
    chk("t6_rst_rows", 64'(rows_done), 64'd0);
    chk("t6_rst_res0", 64'(res_of(0)), 64'd0);
    step();
    flush = '0;
    rst = 1'b0;
    for (int i = 0; i < CH; i++) exp_rows[i] = 0;
    push_l(0, 8'd2);
    push_m(0, 32'd5);
    push_m(0, 32'd6);
    #1;
    wait_valid(0, k);
    chk("t6_latency", 64'(k), 64'd3);
    chk("t6_res", 64'(res_of(0)), 64'd11);
    handshake(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
